// File: rtl/add_op_sequencer.sv
// add_op_sequencer: operand FIFO feeding a combinational adder, with a tagged, registered result channel
module add_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic [31:0]              add_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_sum,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [TAG_W-1:0] mem_t [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TAG_W-1:0] tag_ctr;
  logic push, pop, not_empty;
  always_comb begin
    not_empty = count != '0;
    in_ready  = count != full_cnt;
    push      = in_valid & in_ready;
    pop       = not_empty & (!out_valid | out_ready);
    add_a     = not_empty ? mem_a[rd_ptr] : '0;
    add_b     = not_empty ? mem_b[rd_ptr] : '0;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
      mem_t[wr_ptr] <= tag_ctr;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tag_ctr   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_ctr <= tag_ctr + 1'b1;
      end
      count <= (push & !pop) ? count + 1'b1 : (!push & pop) ? count - 1'b1 : count;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_sum   <= add_sum;
        out_tag   <= mem_t[rd_ptr];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_add_op_sequencer.sv
// tb_add_op_sequencer: directed checks of the adder feeder with a behavioural adder on add_a/add_b
module tb_add_op_sequencer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0, add_a, add_b, add_sum, out_sum;
  logic [7:0] out_tag;
  logic [2:0] count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign add_sum = add_a + add_b;
  add_op_sequencer #(.DEPTH(4), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_tag(out_tag), .count(count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask
  initial begin
    #12 rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_sum", out_sum, 0);
    check("rst_tag", 32'(out_tag), 0);
    in_valid = 1'b1; in_a = 3; in_b = 5;
    step;
    in_valid = 1'b0;
    check("single_count1", 32'(count), 1);
    check("single_valid_e", 32'(out_valid), 0);
    step;
    check("single_valid", 32'(out_valid), 1);
    check("single_sum", out_sum, 8);
    check("single_tag", 32'(out_tag), 0);
    check("single_count0", 32'(count), 0);
    step;
    check("single_drop", 32'(out_valid), 0);
    check("single_hold_sum", out_sum, 8);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 3; in_b = 5;
    step;
    in_valid = 1'b0;
    step;
    check("stall_valid", 32'(out_valid), 1);
    check("stall_sum0", out_sum, 8);
    check("stall_tag0", 32'(out_tag), 1);
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_a = 32'(100 * k); in_b = 32'(k);
      step;
      check("stall_sum", out_sum, 8);
      check("stall_tag", 32'(out_tag), 1);
      check("stall_count", 32'(count), 32'(k));
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_sum", out_sum, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step;
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h2;
    step;
    in_a = 1; in_b = 1;
    step;
    in_valid = 1'b0;
    check("wrap_sum", out_sum, 1);
    check("wrap_tag", 32'(out_tag), 0);
    step;
    check("next_sum", out_sum, 2);
    check("next_tag", 32'(out_tag), 1);
    step;
    check("drain_valid", 32'(out_valid), 0);
    pulse_rst;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_a = 32'(i); in_b = 32'(10 * i);
      step;
    end
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_sum", out_sum, 11);
    check("full_tag", 32'(out_tag), 0);
    in_a = 6; in_b = 60;
    step;
    in_valid = 1'b0;
    check("full_reject_count", 32'(count), 4);
    check("full_reject_sum", out_sum, 11);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_sum", out_sum, 32'(11 * k));
      check("bp_tag", 32'(out_tag), 32'(k - 1));
    end
    step;
    check("bp_end_valid", 32'(out_valid), 0);
    check("bp_end_count", 32'(count), 0);
    pulse_rst;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_a = 32'(i); in_b = 32'(i);
      step;
      check("stream_count", 32'(count <= 3'd1), 1);
      if (i >= 1) begin
        check("stream_sum", out_sum, 32'(2 * (i - 1)));
        check("stream_tag", 32'(out_tag), 32'((i - 1) % 256));
      end
    end
    in_valid = 1'b0;
    step;
    check("stream_last_sum", out_sum, 598);
    check("stream_last_tag", 32'(out_tag), 43);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/add_op_sequencer.md
Name: add_op_sequencer

Overview:
- Upstream feeder for the 32-bit DPI-backed combinational adder.
- Accepts operand pairs over a valid/ready channel and buffers them in a small FIFO.
- Drives the FIFO head onto the adder inputs, registers the adder sum with a sequence tag, and presents it on a valid/ready result channel.
- Decouples the testbench or CPU-side producer from result consumption.

Parameters:
- DEPTH, 4, operand FIFO depth in entries; power of 2, minimum 2.
- TAG_W, 8, width of the sequence tag attached to each request.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents an operand pair.
- in_ready  output  1  sequencer can accept a pair.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- add_a  output  32  to adder in_a; FIFO head operand A.
- add_b  output  32  to adder in_b; FIFO head operand B.
- add_sum  input  32  from adder out_sum; combinational function of add_a/add_b.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  32  registered sum.
- out_tag  output  TAG_W  tag of the request that produced out_sum.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1): FIFO pointers=0, count=0, tag counter=0, out_valid=0, out_sum=0, out_tag=0. Any in-flight entries and a pending result are discarded. in_ready=1 once rst deasserts.
- in_ready = (count != DEPTH). Purely registered-state based; it does not depend on a same-cycle pop.
- push = in_valid & in_ready.
  - On push, store {in_a, in_b, tag_ctr} at the write pointer.
  - tag_ctr increments modulo 2^TAG_W; 2^TAG_W-1 wraps to 0.
- add_a/add_b show the head entry operands while count>0, and 0 when count==0. add_sum is treated as valid in the same cycle (zero-latency adder).
- out_fire = out_valid & out_ready.
- pop = (count>0) & (!out_valid | out_ready).
- On pop:
  - out_sum <= add_sum.
  - out_tag <= head tag.
  - out_valid <= 1.
  - Read pointer advances.
- If out_fire and no pop: out_valid <= 0; out_sum and out_tag hold their last values.
- If out_valid=1 and out_ready=0: out_sum, out_tag and out_valid hold stable (no pop).
- Simultaneous push and pop: count is unchanged; pointers both advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally.
- Latency: a pair accepted at edge E appears on out_* with out_valid=1 after edge E+1, provided the result register is free.
- Throughput: one result per cycle when out_ready is held high.
- Arithmetic: the sum is exactly the adder's 32-bit result, modulo 2^32. No carry out; overflow is not flagged.
- Entries are never reordered and never dropped. The out_tag sequence is strictly consecutive modulo 2^TAG_W.

Test Plan:
- Single op:
  - Stimulus: reset; push a=3, b=5 at edge E; out_ready=1.
  - Response: out_valid=1 after E+1 with out_sum=8, out_tag=0; out_valid=0 after E+2; count returns to 0.
- Wrap-around sum:
  - Stimulus: push a=0xFFFFFFFF, b=0x00000002.
  - Response: out_sum=0x00000001, out_tag increments by one from the previous request.
- Backpressure/full:
  - Stimulus: out_ready=0; push 5 pairs (i, 10*i) for i=1..5.
  - Response: the first pops into the result register; the next 4 fill the FIFO (count=4, in_ready=0); the 6th attempt is not accepted.
  - Then raise out_ready: sums 11, 22, 33, 44, 55 stream one per cycle with tags 0..4.
- Streaming:
  - Stimulus: out_ready=1, in_valid=1 for 300 consecutive pairs (i, i).
  - Response: results 2i in order; out_tag wraps 255->0; count never exceeds 1.
- Reset mid-operation:
  - Stimulus: FIFO holding 3 entries and out_valid=1; assert rst asynchronously between edges.
  - Response: out_valid=0 and count=0 immediately; after release the next push yields out_tag=0.
- Hold under stall:
  - Stimulus: out_valid=1, out_sum=8; toggle in_* for 3 cycles with out_ready=0.
  - Response: out_sum/out_tag remain 8/tag unchanged.
